seq_hit_logger: RTL and testbench

SEQ_HIT_LOGGER -- requirements
Module: seq_hit_logger

---
 rtl/seq_hit_pkg.sv | 10 +
 rtl/hit_fifo.sv | 37 +++
 rtl/seq_hit_logger.sv | 60 ++++++
 tb/tb_seq_hit_logger.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seq_hit_pkg.sv
// seq_hit_pkg: shared defaults and entry sizing for the sequence-hit logger
package seq_hit_pkg;
  localparam int DEPTH_DEF = 4;
  localparam int GAP_W_DEF = 8;
  localparam int CNT_W_DEF = 16;
  localparam int ENTRY_W_DEF = GAP_W_DEF + 1;
  function automatic int entry_w(input int gap_w);
    return gap_w + 1;
  endfunction
endpackage

// File: rtl/hit_fifo.sv
// hit_fifo: synchronous FIFO with occupancy output; head data reads as zero when empty
module hit_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 9,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [LW-1:0] level
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  // masking keeps stale or uninitialised storage off the outputs
  assign rdata = (|level) ? mem[rp] : '0;
endmodule

// File: rtl/seq_hit_logger.sv
// seq_hit_logger: logs {first, gap} for each detector hit into a FIFO, with hit count and sticky overflow
module seq_hit_logger
  import seq_hit_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int GAP_W = GAP_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  localparam int LW = $clog2(DEPTH) + 1,
  localparam int EW = entry_w(GAP_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit,
  input  logic             clr,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [GAP_W-1:0] rd_gap,
  output logic             rd_first,
  output logic [CNT_W-1:0] hit_count,
  output logic [LW-1:0]    fifo_level,
  output logic             overflow
);
  logic [GAP_W-1:0] gap;
  logic armed, take, pop, full, push;
  logic [EW-1:0] head;
  assign take = hit && !clr;
  assign rd_valid = |fifo_level;
  assign pop = rd_valid && rd_ready;
  assign full = fifo_level == LW'(DEPTH);
  // a full FIFO still accepts when the head leaves in the same cycle
  assign push = take && (!full || pop);
  assign {rd_first, rd_gap} = head;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      gap <= '0;
      armed <= 1'b1;
      hit_count <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      gap <= '0;
      armed <= 1'b1;
      hit_count <= '0;
      overflow <= 1'b0;
    end else begin
      gap <= hit ? '0 : (&gap ? gap : gap + 1'b1);
      if (hit) armed <= 1'b0;
      if (hit) hit_count <= hit_count + 1'b1;
      if (take && !push) overflow <= 1'b1;
    end
  hit_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .push(push),
    .pop(pop),
    .wdata({armed, gap}),
    .rdata(head),
    .level(fifo_level)
  );
endmodule

// File: tb/tb_seq_hit_logger.sv
// tb_seq_hit_logger: directed and random stimulus checked against a cycle-stamp/queue model
module tb_seq_hit_logger;
  localparam int DEPTH = 4;
  localparam int GMAX = 255;
  logic clk = 1'b1, rst = 1'b0, hit = 1'b0, clr = 1'b0, rd_ready = 1'b0;
  logic rd_valid, rd_first, overflow;
  logic [7:0] rd_gap;
  logic [15:0] hit_count;
  logic [2:0] fifo_level;
  int tests = 0, fails = 0;
  typedef struct packed {logic first; logic [7:0] gap;} ent_t;
  ent_t q[$];
  int cnt;
  bit ovf, armed;
  longint cyc, last_ev;

  seq_hit_logger dut (
    .clk(clk), .rst(rst), .hit(hit), .clr(clr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_gap(rd_gap), .rd_first(rd_first),
    .hit_count(hit_count), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cnt = 0;
    ovf = 0;
    armed = 1;
    cyc = 0;
    last_ev = -1;
  endtask

  task automatic model_step(input bit h, input bit c, input bit r);
    ent_t e;
    bit pop;
    longint g;
    if (c) begin
      q.delete();
      cnt = 0;
      ovf = 0;
      armed = 1;
      last_ev = cyc;
    end else begin
      pop = (q.size() != 0) && r;
      if (h) begin
        g = cyc - last_ev - 1;
        e.first = armed;
        e.gap = 8'((g > GMAX) ? GMAX : g);
        armed = 0;
        cnt++;
        last_ev = cyc;
      end
      if (pop) void'(q.pop_front());
      if (h) begin
        if (q.size() < DEPTH) q.push_back(e);
        else ovf = 1;
      end
    end
    cyc++;
  endtask

  task automatic check_all();
    chk("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
    chk("rd_gap", 32'(rd_gap), 32'(q.size() != 0 ? q[0].gap : 8'd0));
    chk("rd_first", 32'(rd_first), 32'(q.size() != 0 ? q[0].first : 1'b0));
    chk("hit_count", 32'(hit_count), 32'(cnt & 16'hFFFF));
    chk("fifo_level", 32'(fifo_level), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(ovf));
  endtask

  task automatic step(input bit h, input bit c, input bit r);
    hit = h;
    clr = c;
    rd_ready = r;
    @(posedge clk);
    model_step(h, c, r);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    model_reset();
    #15;
    check_all();
    rst = 1'b1;
    // two hits at cycles 4 and 9 with the consumer always ready
    for (int c = 0; c < 10; c++) begin
      step(c == 4 || c == 9, 0, 1);
      if (c == 4) begin
        chk("req33_gap0", 32'(rd_gap), 32'd4);
        chk("req33_first0", 32'(rd_first), 32'd1);
      end
      if (c == 9) begin
        chk("req33_gap1", 32'(rd_gap), 32'd4);
        chk("req33_first1", 32'(rd_first), 32'd0);
        chk("req33_cnt", 32'(hit_count), 32'd2);
      end
    end
    step(0, 0, 1);
    // five hits three cycles apart into a stalled consumer
    step(0, 1, 0);
    for (int i = 0; i < 15; i++) step(i % 3 == 0, 0, 0);
    chk("req34_level", 32'(fifo_level), 32'd4);
    chk("req34_ovf", 32'(overflow), 32'd1);
    chk("req34_cnt", 32'(hit_count), 32'd5);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("req34_lastgap", 32'(rd_gap), 32'd2);
      step(0, 0, 1);
    end
    // long idle saturates the gap
    step(0, 1, 1);
    for (int i = 0; i < 300; i++) step(0, 0, 1);
    step(1, 0, 0);
    chk("req35_gap", 32'(rd_gap), 32'd255);
    // full FIFO with a same-cycle hit and pop
    step(0, 1, 0);
    for (int i = 0; i < 8; i++) step(i % 2 == 0, 0, 0);
    step(1, 0, 1);
    chk("req36_level", 32'(fifo_level), 32'd4);
    chk("req36_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    // clear wins over a coincident hit
    step(0, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    chk("req37_level", 32'(fifo_level), 32'd0);
    chk("req37_cnt", 32'(hit_count), 32'd0);
    chk("req37_ovf", 32'(overflow), 32'd0);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("req37_first", 32'(rd_first), 32'd1);
    step(0, 0, 1);
    // back-to-back hits, then asynchronous reset mid-stream
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 1);
    chk("req38_gap0", 32'(rd_gap), 32'd0);
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    check_all();
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 1);
    chk("rst_gap", 32'(rd_gap), 32'd0);
    // random traffic with occasional clear and reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
      end
      step($urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
